dual_rr_arbiter: RTL and testbench

- Shares two identical resource channels (ch0, ch1) among REQ_WIDTH level-sensitive requesters.
- Uses round-robin dual-priority selection, so up to two requesters are served at once.
- Each grant is held until the channel reports done, the requester withdraws, or a hold timeout expires.
- Grant indices are in the same binary form the display path accepts, so current owners can be shown directly on the seven-segment mux.

---
 rtl/dual_rr_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dual_rr_arbiter.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/dual_rr_arbiter.sv
// dual_rr_arbiter
// Shares two identical resource channels (ch0, ch1) among REQ_WIDTH
// level-sensitive requesters using round-robin dual-priority selection.
// Each grant is held until the channel reports done, the requester drops
// its request, or the hold timeout (MAX_HOLD busy cycles) expires.
//
// Ports:
//   clk        - system clock, rising edge
//   reset_n    - synchronous active-low reset
//   req        - level request per requester
//   ch0_done   - ch0 finished its current job (ignored while idle)
//   ch1_done   - ch1 finished its current job (ignored while idle)
//   gnt0_valid - ch0 is owned
//   gnt0_idx   - ch0 owner index (holds last value while not valid)
//   gnt1_valid - ch1 is owned
//   gnt1_idx   - ch1 owner index (holds last value while not valid)
//   gnt_vec    - one-hot-per-owner view of both grants
//   timeout    - one-cycle pulse after a forced release on either channel
module dual_rr_arbiter #(
    parameter int REQ_WIDTH = 12,
    parameter int MAX_HOLD  = 1024,
    localparam int IW       = $clog2(REQ_WIDTH)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REQ_WIDTH-1:0] req,
    input  logic                 ch0_done,
    input  logic                 ch1_done,
    output logic                 gnt0_valid,
    output logic [IW-1:0]        gnt0_idx,
    output logic                 gnt1_valid,
    output logic [IW-1:0]        gnt1_idx,
    output logic [REQ_WIDTH-1:0] gnt_vec,
    output logic                 timeout
);

    localparam int CW = $clog2(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } ch_state_t;

    ch_state_t      state      [2];
    ch_state_t      state_next [2];
    logic [IW-1:0]  owner      [2];
    logic [IW-1:0]  owner_next [2];
    logic [CW-1:0]  cnt        [2];
    logic [CW-1:0]  cnt_next   [2];
    logic [IW-1:0]  ptr;
    logic [IW-1:0]  ptr_next;
    logic           timeout_next;

    logic                 done      [2];
    logic                 release_c [2];
    logic                 forced    [2];
    logic                 grant     [2];
    logic [IW-1:0]        grant_idx [2];
    logic [REQ_WIDTH-1:0] own_mask;
    logic [REQ_WIDTH-1:0] cand;
    logic                 first_found;
    logic [IW-1:0]        first_idx;
    logic                 second_found;
    logic [IW-1:0]        second_idx;
    logic [IW-1:0]        pos;
    logic [IW-1:0]        last_idx;

    assign done[0] = ch0_done;
    assign done[1] = ch1_done;

    // Release detection and the ownership mask both use pre-edge state, so
    // a releasing owner is still masked and cannot hop to the other channel.
    always_comb begin
        own_mask = '0;
        for (int c = 0; c < 2; c++) begin
            forced[c]    = (state[c] == BUSY) && (cnt[c] == CW'(MAX_HOLD - 1));
            release_c[c] = (state[c] == BUSY) &&
                           (done[c] || !req[owner[c]] || forced[c]);
            if (state[c] == BUSY) begin
                own_mask[owner[c]] = 1'b1;
            end
        end
        cand = req & ~own_mask;
    end

    // Circular search starting at ptr for the first two candidates.
    always_comb begin
        first_found  = 1'b0;
        first_idx    = '0;
        second_found = 1'b0;
        second_idx   = '0;
        pos          = ptr;
        for (int k = 0; k < REQ_WIDTH; k++) begin
            if (cand[pos]) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = pos;
                end else if (!second_found) begin
                    second_found = 1'b1;
                    second_idx   = pos;
                end
            end
            pos = (pos == IW'(REQ_WIDTH - 1)) ? '0 : pos + IW'(1);
        end
    end

    // Only channels idle before the edge may be granted; a channel releasing
    // this cycle becomes idle at the edge and can be re-granted one cycle later.
    always_comb begin
        grant[0]     = 1'b0;
        grant[1]     = 1'b0;
        grant_idx[0] = first_idx;
        grant_idx[1] = first_idx;
        last_idx     = first_idx;
        if (state[0] == IDLE && state[1] == IDLE) begin
            grant[0]     = first_found;
            grant[1]     = second_found;
            grant_idx[1] = second_idx;
            if (second_found) begin
                last_idx = second_idx;
            end
        end else if (state[0] == IDLE) begin
            grant[0] = first_found;
        end else if (state[1] == IDLE) begin
            grant[1] = first_found;
        end
        ptr_next = ptr;
        if (grant[0] || grant[1]) begin
            ptr_next = (last_idx == IW'(REQ_WIDTH - 1)) ? '0 : last_idx + IW'(1);
        end
    end

    // Per-channel next state: busy channels count and release, idle channels
    // accept a grant and restart their hold counter.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_next[c] = state[c];
            owner_next[c] = owner[c];
            cnt_next[c]   = cnt[c];
            if (state[c] == BUSY) begin
                if (release_c[c]) begin
                    state_next[c] = IDLE;
                end else begin
                    cnt_next[c] = cnt[c] + CW'(1);
                end
            end else if (grant[c]) begin
                state_next[c] = BUSY;
                owner_next[c] = grant_idx[c];
                cnt_next[c]   = '0;
            end
        end
        timeout_next = forced[0] || forced[1];
    end

    // State register; reset drops ownership immediately without waiting for done.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int c = 0; c < 2; c++) begin
                state[c] <= IDLE;
                owner[c] <= '0;
                cnt[c]   <= '0;
            end
            ptr     <= '0;
            timeout <= 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                state[c] <= state_next[c];
                owner[c] <= owner_next[c];
                cnt[c]   <= cnt_next[c];
            end
            ptr     <= ptr_next;
            timeout <= timeout_next;
        end
    end

    assign gnt0_valid = (state[0] == BUSY);
    assign gnt1_valid = (state[1] == BUSY);
    assign gnt0_idx   = owner[0];
    assign gnt1_idx   = owner[1];

    // Owner vector decoded from the registered grants.
    always_comb begin
        gnt_vec = '0;
        for (int c = 0; c < 2; c++) begin
            if (state[c] == BUSY) begin
                gnt_vec[owner[c]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dual_rr_arbiter.sv
// tb_dual_rr_arbiter
// Directed, table-driven bench for dual_rr_arbiter (REQ_WIDTH=12, MAX_HOLD=8).
// Each table row drives inputs for one cycle and lists the outputs expected
// just after the following rising edge. The timeout corner is a hand sequence.
module tb_dual_rr_arbiter;

    logic        clk;
    logic        reset_n;
    logic [11:0] req;
    logic        ch0_done;
    logic        ch1_done;
    logic        gnt0_valid;
    logic [3:0]  gnt0_idx;
    logic        gnt1_valid;
    logic [3:0]  gnt1_idx;
    logic [11:0] gnt_vec;
    logic        timeout;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [11:0] req;
        logic        d0;
        logic        d1;
        logic        v0;
        logic [3:0]  i0;
        logic        v1;
        logic [3:0]  i1;
        logic [11:0] vec;
        logic        to;
    } vec_t;

    vec_t vecs[$];

    dual_rr_arbiter #(
        .REQ_WIDTH (12),
        .MAX_HOLD  (8)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .ch0_done   (ch0_done),
        .ch1_done   (ch1_done),
        .gnt0_valid (gnt0_valid),
        .gnt0_idx   (gnt0_idx),
        .gnt1_valid (gnt1_valid),
        .gnt1_idx   (gnt1_idx),
        .gnt_vec    (gnt_vec),
        .timeout    (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_vec(input string name, input logic rst_n,
                                    input logic [11:0] r, input logic d0,
                                    input logic d1, input logic v0,
                                    input logic [3:0] i0, input logic v1,
                                    input logic [3:0] i1, input logic [11:0] vec,
                                    input logic to);
        vec_t v;
        v.name = name; v.rst_n = rst_n; v.req = r; v.d0 = d0; v.d1 = d1;
        v.v0 = v0; v.i0 = i0; v.v1 = v1; v.i1 = i1; v.vec = vec; v.to = to;
        vecs.push_back(v);
    endfunction

    task automatic check_output(input string name, input logic [11:0] act,
                                input logic [11:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic apply_stimulus(input logic rst_n, input logic [11:0] r,
                                  input logic d0, input logic d1);
        reset_n  = rst_n;
        req      = r;
        ch0_done = d0;
        ch1_done = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string name, input logic v0, input logic [3:0] i0,
                             input logic v1, input logic [3:0] i1,
                             input logic [11:0] vec, input logic to);
        check_output({name, ".v0"},  12'(gnt0_valid), 12'(v0));
        check_output({name, ".i0"},  12'(gnt0_idx),   12'(i0));
        check_output({name, ".v1"},  12'(gnt1_valid), 12'(v1));
        check_output({name, ".i1"},  12'(gnt1_idx),   12'(i1));
        check_output({name, ".vec"}, gnt_vec,         vec);
        check_output({name, ".to"},  12'(timeout),    12'(to));
    endtask

    initial begin
        reset_n  = 1'b0;
        req      = '0;
        ch0_done = 1'b0;
        ch1_done = 1'b0;

        // Reset with all requests high, then first grant pair
        for (int n = 0; n < 3; n++)
            add_vec("rst_hold", 1'b0, 12'hFFF, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 1'b0);
        add_vec("rst_rel", 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b1, 4'd0, 1'b1, 4'd1, 12'h003, 1'b0);

        // Round-robin rotation, both dones every 4 cycles; continues up to (8,9)
        for (int k = 0; k < 10; k++) begin
            int a, b, na, nb;
            logic [11:0] cur, nxt;
            a = (2 * k) % 12;      b = a + 1;
            na = (2 * k + 2) % 12; nb = na + 1;
            cur = '0; cur[a] = 1'b1; cur[b] = 1'b1;
            nxt = '0; nxt[na] = 1'b1; nxt[nb] = 1'b1;
            add_vec("rr_hold", 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b1, 4'(a), 1'b1, 4'(b), cur, 1'b0);
            add_vec("rr_hold", 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b1, 4'(a), 1'b1, 4'(b), cur, 1'b0);
            add_vec("rr_done", 1'b1, 12'hFFF, 1'b1, 1'b1, 1'b0, 4'(a), 1'b0, 4'(b), 12'h000, 1'b0);
            add_vec("rr_grant", 1'b1, 12'hFFF, 1'b0, 1'b0, 1'b1, 4'(na), 1'b1, 4'(nb), nxt, 1'b0);
        end

        // Wrap and mask from ptr=10
        add_vec("wrap_drop", 1'b1, 12'h803, 1'b0, 1'b0, 1'b0, 4'd8, 1'b0, 4'd9, 12'h000, 1'b0);
        add_vec("wrap_grant", 1'b1, 12'h803, 1'b0, 1'b0, 1'b1, 4'd11, 1'b1, 4'd0, 12'h801, 1'b0);
        add_vec("wrap_done0", 1'b1, 12'h803, 1'b1, 1'b0, 1'b0, 4'd11, 1'b1, 4'd0, 12'h001, 1'b0);
        add_vec("wrap_regrant", 1'b1, 12'h803, 1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 4'd0, 12'h003, 1'b0);

        // Single requester, idle done ignored, withdrawal release
        add_vec("single_drop", 1'b1, 12'h020, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0, 4'd0, 12'h000, 1'b0);
        add_vec("single_grant", 1'b1, 12'h020, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 4'd0, 12'h020, 1'b0);
        add_vec("single_idle_done", 1'b1, 12'h020, 1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 4'd0, 12'h020, 1'b0);
        add_vec("single_withdraw", 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 4'd0, 12'h000, 1'b0);

        // Mid-operation reset, then arbitration restarts from ptr=0
        add_vec("mid_rst0", 1'b0, 12'h088, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 1'b0);
        add_vec("mid_grant", 1'b1, 12'h088, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd7, 12'h088, 1'b0);
        add_vec("mid_hold", 1'b1, 12'h088, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd7, 12'h088, 1'b0);
        add_vec("mid_rst", 1'b0, 12'h088, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 12'h000, 1'b0);
        add_vec("mid_restart", 1'b1, 12'h108, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd8, 12'h108, 1'b0);
        add_vec("mid_drop", 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 4'd8, 12'h000, 1'b0);

        foreach (vecs[n]) begin
            apply_stimulus(vecs[n].rst_n, vecs[n].req, vecs[n].d0, vecs[n].d1);
            check_all(vecs[n].name, vecs[n].v0, vecs[n].i0, vecs[n].v1,
                      vecs[n].i1, vecs[n].vec, vecs[n].to);
        end

        // Timeout: grant held exactly 8 cycles, pulse, then re-grant
        for (int n = 1; n <= 8; n++) begin
            apply_stimulus(1'b1, 12'h001, 1'b0, 1'b0);
            check_all($sformatf("to_busy%0d", n), 1'b1, 4'd0, 1'b0, 4'd8, 12'h001, 1'b0);
        end
        apply_stimulus(1'b1, 12'h001, 1'b0, 1'b0);
        check_all("to_release", 1'b0, 4'd0, 1'b0, 4'd8, 12'h000, 1'b1);
        apply_stimulus(1'b1, 12'h001, 1'b0, 1'b0);
        check_all("to_regrant", 1'b1, 4'd0, 1'b0, 4'd8, 12'h001, 1'b0);
        apply_stimulus(1'b1, 12'h000, 1'b0, 1'b0);
        check_all("to_withdraw", 1'b0, 4'd0, 1'b0, 4'd8, 12'h000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
